load_store_unit: RTL and testbench

Initiator side of the processor's data-memory interface: accepts one load/store request at a time from the execute stage and drives the byte-addressed, big-endian, registered-read data memory (`memRead`/`memWrite`/`address`/`writeData`/`readData`). Word ops map to a single memory access; byte and halfword stores become a read-modify-write on the aligned word; sub-word loads are extracted and sign- or zero-extended. It sits between the pipeline's MEM stage and the data memory.

---
 rtl/lsu_pkg.sv | 58 +++++
 rtl/lsu_lane_align.sv | 62 ++++++
 rtl/load_store_unit.sv | 166 ++++++++++++++++
 tb/tb_load_store_unit.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: request op codes, FSM states,
// access sizes and the big-endian lane constants used by the lane aligner.
package lsu_pkg;

  typedef enum logic [2:0] {
    OP_LW  = 3'd0,
    OP_LH  = 3'd1,
    OP_LHU = 3'd2,
    OP_LB  = 3'd3,
    OP_LBU = 3'd4,
    OP_SW  = 3'd5,
    OP_SH  = 3'd6,
    OP_SB  = 3'd7
  } lsu_op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_EXT,
    ST_MERGE,
    ST_WR
  } lsu_state_e;

  typedef enum logic [1:0] {
    SZ_BYTE,
    SZ_HALF,
    SZ_WORD
  } lsu_size_e;

  localparam int LANES = 4;
  // Big-endian: byte offset 0 is bits [31:24]; the low half starts at offset 2.
  localparam logic [1:0] HALF_LO_OFF = 2'd2;

  function automatic lsu_size_e op_size(lsu_op_e op);
    case (op)
      OP_LW, OP_SW:         return SZ_WORD;
      OP_LH, OP_LHU, OP_SH: return SZ_HALF;
      default:              return SZ_BYTE;
    endcase
  endfunction

  function automatic logic op_is_store(lsu_op_e op);
    return (op == OP_SW) || (op == OP_SH) || (op == OP_SB);
  endfunction

  function automatic logic op_is_signed(lsu_op_e op);
    return (op == OP_LH) || (op == OP_LB);
  endfunction

  function automatic logic misaligned(lsu_op_e op, logic [1:0] off);
    case (op_size(op))
      SZ_WORD: return off != 2'd0;
      SZ_HALF: return off[0];
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational big-endian lane logic: extracts a byte/half/word with sign or
// zero extension, and merges store data into the selected lanes of a word.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  offset,
  input  lsu_size_e   size,
  input  logic        is_signed,
  input  logic [31:0] data,
  output logic [31:0] extracted,
  output logic [31:0] merged
);

  logic [7:0]  lanes [LANES];
  logic        half_lo;
  logic [7:0]  byte_val;
  logic [15:0] half_val;

  // Halfword ops only look at offset bit 1, which truncates odd addresses.
  assign half_lo = (offset & HALF_LO_OFF) != 2'd0;

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      localparam logic [1:0] LANE = 2'(gi);
      logic       hit;
      logic [7:0] ins;

      assign lanes[gi] = word[31-8*gi -: 8];

      always_comb begin
        hit = 1'b1;
        ins = data[31-8*gi -: 8];
        unique case (size)
          SZ_BYTE: begin
            hit = (offset == LANE);
            ins = data[7:0];
          end
          SZ_HALF: begin
            hit = (LANE[1] == half_lo);
            ins = LANE[0] ? data[7:0] : data[15:8];
          end
          default: ;
        endcase
      end

      assign merged[31-8*gi -: 8] = hit ? ins : lanes[gi];
    end
  endgenerate

  always_comb begin
    byte_val = lanes[offset];
    half_val = half_lo ? word[15:0] : word[31:16];
    unique case (size)
      SZ_BYTE: extracted = {{24{is_signed & byte_val[7]}}, byte_val};
      SZ_HALF: extracted = {{16{is_signed & half_val[15]}}, half_val};
      default: extracted = word;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit driving a big-endian, registered-read data memory; sub-word
// stores are read-modify-write. Define LSU_ALIGN_CHECK_EN to reject misaligned ops.
module load_store_unit
  import lsu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        memRead,
  output logic        memWrite,
  output logic [31:0] address,
  output logic [31:0] writeData,
  input  logic [31:0] readData
);

  lsu_state_e  state_reg, state_next;
  lsu_op_e     op_reg, op_next;
  logic [1:0]  off_reg, off_next;
  logic [31:0] wdata_reg, wdata_next;
  logic        err_reg, err_next;
  logic        mem_read_reg, mem_read_next;
  logic        mem_write_reg, mem_write_next;
  logic [31:0] address_reg, address_next;
  logic [31:0] write_data_reg, write_data_next;
  logic        resp_valid_reg, resp_valid_next;
  logic [31:0] resp_rdata_reg, resp_rdata_next;
  logic        resp_err_reg, resp_err_next;

  lsu_op_e     in_op;
  logic        accept;
  logic        in_misaligned;
  lsu_size_e   cur_size;
  logic        cur_signed;
  logic [31:0] extracted;
  logic [31:0] merged;

  assign in_op      = lsu_op_e'(req_op);
  assign req_ready  = (state_reg == ST_IDLE);
  assign accept     = req_valid && req_ready;
  assign cur_size   = op_size(op_reg);
  assign cur_signed = op_is_signed(op_reg);

`ifdef LSU_ALIGN_CHECK_EN
  assign in_misaligned = misaligned(in_op, req_addr[1:0]);
`else
  assign in_misaligned = 1'b0;
`endif

  lsu_lane_align u_align (
    .word      (readData),
    .offset    (off_reg),
    .size      (cur_size),
    .is_signed (cur_signed),
    .data      (wdata_reg),
    .extracted (extracted),
    .merged    (merged)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg      <= ST_IDLE;
      op_reg         <= OP_LW;
      off_reg        <= '0;
      wdata_reg      <= '0;
      err_reg        <= 1'b0;
      mem_read_reg   <= 1'b0;
      mem_write_reg  <= 1'b0;
      address_reg    <= '0;
      write_data_reg <= '0;
      resp_valid_reg <= 1'b0;
      resp_rdata_reg <= '0;
      resp_err_reg   <= 1'b0;
    end else begin
      state_reg      <= state_next;
      op_reg         <= op_next;
      off_reg        <= off_next;
      wdata_reg      <= wdata_next;
      err_reg        <= err_next;
      mem_read_reg   <= mem_read_next;
      mem_write_reg  <= mem_write_next;
      address_reg    <= address_next;
      write_data_reg <= write_data_next;
      resp_valid_reg <= resp_valid_next;
      resp_rdata_reg <= resp_rdata_next;
      resp_err_reg   <= resp_err_next;
    end
  end

  // A rejected request parks in EXT for one cycle so its error response
  // lands one edge after acceptance without touching memory.
  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      ST_IDLE: begin
        if (accept) begin
          if (in_misaligned)        state_next = ST_EXT;
          else if (in_op == OP_SW)  state_next = ST_WR;
          else                      state_next = ST_RD;
        end
      end
      ST_RD:    state_next = op_is_store(op_reg) ? ST_MERGE : ST_EXT;
      ST_MERGE: state_next = ST_WR;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    op_next         = op_reg;
    off_next        = off_reg;
    wdata_next      = wdata_reg;
    err_next        = err_reg;
    mem_read_next   = 1'b0;
    mem_write_next  = 1'b0;
    address_next    = address_reg;
    write_data_next = write_data_reg;
    resp_valid_next = 1'b0;
    resp_rdata_next = resp_rdata_reg;
    resp_err_next   = 1'b0;
    unique case (state_reg)
      ST_IDLE: begin
        if (accept) begin
          op_next    = in_op;
          off_next   = req_addr[1:0];
          wdata_next = req_wdata;
          err_next   = in_misaligned;
          if (!in_misaligned) begin
            address_next   = {req_addr[31:2], 2'b00};
            mem_read_next  = (in_op != OP_SW);
            mem_write_next = (in_op == OP_SW);
            if (in_op == OP_SW) write_data_next = req_wdata;
          end
        end
      end
      ST_EXT: begin
        resp_valid_next = 1'b1;
        resp_err_next   = err_reg;
        resp_rdata_next = err_reg ? 32'd0 : extracted;
      end
      ST_MERGE: begin
        mem_write_next  = 1'b1;
        write_data_next = merged;
      end
      ST_WR: begin
        resp_valid_next = 1'b1;
        resp_rdata_next = 32'd0;
      end
      default: ;
    endcase
  end

  assign memRead    = mem_read_reg;
  assign memWrite   = mem_write_reg;
  assign address    = address_reg;
  assign writeData  = write_data_reg;
  assign resp_valid = resp_valid_reg;
  assign resp_rdata = resp_rdata_reg;
  assign resp_err   = resp_err_reg;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: a registered-read memory model, a
// reference word model for expected load data, and pulse/latency monitoring.
module tb_load_store_unit;
  import lsu_pkg::*;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          c0;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        memRead;
  logic        memWrite;
  logic [31:0] address;
  logic [31:0] writeData;
  logic [31:0] readData;

  logic [31:0] mem [64];
  logic [31:0] model_mem [64];
  logic        init_en;
  exp_t        sb[$];
  int          cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  int          rd_cnt = 0;
  int          wr_cnt = 0;
  logic [31:0] last_rd_addr = '0;
  logic [31:0] last_wr_addr = '0;
  logic [31:0] last_wr_data = '0;

  lsu_op_e     d_op   [4] = '{OP_LB, OP_LBU, OP_LH, OP_LHU};
  logic [31:0] d_addr [4] = '{32'h11, 32'h11, 32'h12, 32'h10};
  logic [31:0] d_exp  [4] = '{32'hFFFFFF99, 32'h00000099, 32'hFFFFAABB, 32'h00008899};

  load_store_unit dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .memRead    (memRead),
    .memWrite   (memWrite),
    .address    (address),
    .writeData  (writeData),
    .readData   (readData)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] init_word(int i);
    if (i == 4) return 32'h8899AABB;
    return (32'(i) * 32'h01010101) ^ 32'h3C5A9600;
  endfunction

  always @(posedge clk) begin
    if (init_en) begin
      for (int i = 0; i < 64; i++) mem[i] <= init_word(i);
    end else begin
      if (memRead)  readData <= mem[address[7:2]];
      if (memWrite) mem[address[7:2]] <= writeData;
    end
  end

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (memRead || memWrite) begin
      check("rw_exclusive", 32'(memRead & memWrite), 32'd0);
      check("addr_aligned", 32'(address[1:0]), 32'd0);
    end
    if (memRead) begin
      rd_cnt++;
      last_rd_addr = address;
    end
    if (memWrite) begin
      wr_cnt++;
      last_wr_addr = address;
      last_wr_data = writeData;
    end
    if (resp_valid) begin
      if (sb.size() == 0) begin
        check("unexpected_resp", 32'(resp_valid), 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("resp_rdata", resp_rdata, e.rdata);
        check("resp_err", 32'(resp_err), 32'(e.err));
        check("resp_latency", 32'(cyc - e.c0), 32'(e.lat));
        $display("resp cyc=%0d rdata=0x%08h err=%0b", cyc, resp_rdata, resp_err);
      end
    end
  end

  function automatic logic model_misaligned(lsu_op_e op, logic [1:0] lo);
    logic m;
    m = 1'b0;
`ifdef LSU_ALIGN_CHECK_EN
    if (op == OP_LW || op == OP_SW) m = (lo != 2'd0);
    if (op == OP_LH || op == OP_LHU || op == OP_SH) m = lo[0];
`else
    m = m & (op == OP_LW) & lo[0];
`endif
    return m;
  endfunction

  function automatic logic [31:0] model_load(lsu_op_e op, logic [31:0] a);
    logic [31:0] w;
    logic [31:0] v;
    int sh;
    w = model_mem[a[7:2]];
    case (op)
      OP_LB, OP_LBU: begin
        sh = 24 - 8 * int'(a[1:0]);
        v = (w >> sh) & 32'hFF;
        if (op == OP_LB && v[7]) v = v | 32'hFFFFFF00;
      end
      OP_LH, OP_LHU: begin
        sh = a[1] ? 0 : 16;
        v = (w >> sh) & 32'hFFFF;
        if (op == OP_LH && v[15]) v = v | 32'hFFFF0000;
      end
      default: v = w;
    endcase
    return v;
  endfunction

  task automatic model_store(lsu_op_e op, logic [31:0] a, logic [31:0] d);
    logic [31:0] m;
    int sh;
    case (op)
      OP_SB:   begin sh = 24 - 8 * int'(a[1:0]); m = 32'hFF << sh; end
      OP_SH:   begin sh = a[1] ? 0 : 16; m = 32'hFFFF << sh; end
      default: begin sh = 0; m = 32'hFFFFFFFF; end
    endcase
    model_mem[a[7:2]] = (model_mem[a[7:2]] & ~m) | ((d << sh) & m);
  endtask

  task automatic send(lsu_op_e op, logic [31:0] addr, logic [31:0] wdata,
                      logic [31:0] exp_rdata, logic exp_err, int lat,
                      bit want_resp, output logic rv_at_accept);
    int guard;
    guard = 0;
    req_valid = 1'b1;
    req_op    = op;
    req_addr  = addr;
    req_wdata = wdata;
    while (!req_ready && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    check("ready_wait", 32'(req_ready), 32'd1);
    rv_at_accept = resp_valid;
    @(posedge clk); #1;
    $display("req cyc=%0d op=%s addr=0x%08h wdata=0x%08h", cyc, op.name(), addr, wdata);
    req_valid = 1'b0;
    req_op    = 3'($urandom);
    req_addr  = $urandom;
    req_wdata = $urandom;
    if (want_resp) sb.push_back('{exp_rdata, exp_err, lat, cyc});
  endtask

  task automatic issue(lsu_op_e op, logic [31:0] addr, logic [31:0] wdata);
    logic [31:0] exp_rdata;
    logic        err;
    logic        rv;
    int          lat;
    exp_rdata = 32'd0;
    err = model_misaligned(op, addr[1:0]);
    if (err || op == OP_SW)              lat = 1;
    else if (op == OP_SH || op == OP_SB) lat = 3;
    else                                 lat = 2;
    if (!err) begin
      if (op == OP_SW || op == OP_SH || op == OP_SB) model_store(op, addr, wdata);
      else exp_rdata = model_load(op, addr);
    end
    send(op, addr, wdata, exp_rdata, err, lat, 1'b1, rv);
  endtask

  task automatic wait_drain();
    int guard;
    guard = 0;
    while (sb.size() != 0 && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    check("drain", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    logic rv;
    int   rd0;
    int   wr0;
    rst_n = 1'b0; req_valid = 1'b0; req_op = '0; req_addr = '0; req_wdata = '0;
    init_en = 1'b1;
    for (int i = 0; i < 64; i++) model_mem[i] = init_word(i);
    repeat (3) @(posedge clk);
    #1;
    init_en = 1'b0;
    check("rst_req_ready",  32'(req_ready),  32'd1);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_resp_rdata", resp_rdata,      32'd0);
    check("rst_resp_err",   32'(resp_err),   32'd0);
    check("rst_memRead",    32'(memRead),    32'd0);
    check("rst_memWrite",   32'(memWrite),   32'd0);
    check("rst_address",    address,         32'd0);
    check("rst_writeData",  writeData,       32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    rd0 = rd_cnt; wr0 = wr_cnt;
    send(OP_LW, 32'h10, 32'h0, 32'h8899AABB, 1'b0, 2, 1'b1, rv);
    wait_drain();
    check("lw_rd_pulses", 32'(rd_cnt - rd0), 32'd1);
    check("lw_rd_addr",   last_rd_addr,      32'h10);
    check("lw_wr_pulses", 32'(wr_cnt - wr0), 32'd0);

    for (int i = 0; i < 4; i++) send(d_op[i], d_addr[i], 32'h0, d_exp[i], 1'b0, 2, 1'b1, rv);
    wait_drain();

    rd0 = rd_cnt; wr0 = wr_cnt;
    issue(OP_SB, 32'h13, 32'h000000CC);
    wait_drain();
    check("sb_rd_pulses", 32'(rd_cnt - rd0), 32'd1);
    check("sb_wr_pulses", 32'(wr_cnt - wr0), 32'd1);
    check("sb_wr_addr",   last_wr_addr,      32'h10);
    check("sb_wr_data",   last_wr_data,      32'h8899AACC);
    send(OP_LW, 32'h10, 32'h0, 32'h8899AACC, 1'b0, 2, 1'b1, rv);
    wait_drain();

    issue(OP_SW, 32'h20, 32'hDEADBEEF);
    send(OP_LW, 32'h20, 32'h0, 32'hDEADBEEF, 1'b0, 2, 1'b1, rv);
    check("b2b_accept_on_resp", 32'(rv), 32'd1);
    wait_drain();

    rd0 = rd_cnt; wr0 = wr_cnt;
    issue(OP_LW, 32'h06, 32'h0);
    wait_drain();
`ifdef LSU_ALIGN_CHECK_EN
    check("mis_rd_pulses", 32'(rd_cnt - rd0), 32'd0);
`else
    check("mis_rd_pulses", 32'(rd_cnt - rd0), 32'd1);
    check("mis_rd_addr",   last_rd_addr,      32'h04);
`endif
    check("mis_wr_pulses", 32'(wr_cnt - wr0), 32'd0);

    // SH dropped by a reset asserted while the unit sits in MERGE.
    wr0 = wr_cnt;
    send(OP_SH, 32'h12, 32'h00001234, 32'h0, 1'b0, 3, 1'b0, rv);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("rst_mid_ready",      32'(req_ready),  32'd1);
    check("rst_mid_memWrite",   32'(memWrite),   32'd0);
    check("rst_mid_resp_valid", 32'(resp_valid), 32'd0);
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("rst_mid_wr_pulses", 32'(wr_cnt - wr0), 32'd0);
    send(OP_LW, 32'h10, 32'h0, 32'h8899AACC, 1'b0, 2, 1'b1, rv);
    wait_drain();

    for (int i = 0; i < 40; i++) begin
      lsu_op_e op;
      op = lsu_op_e'(3'($urandom_range(0, 7)));
      issue(op, 32'($urandom_range(0, 255)), $urandom);
      if ($urandom_range(0, 3) == 0) wait_drain();
    end
    wait_drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
